// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM state type and opcode legality check for alu_pipe
package alu_pkg;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0001;
  localparam logic [3:0] ALUC_AND = 4'b0010;
  localparam logic [3:0] ALUC_OR  = 4'b0011;
  localparam logic [3:0] ALUC_XOR = 4'b0100;
  localparam logic [3:0] ALUC_LUI = 4'b0101;
  localparam logic [3:0] ALUC_SLL = 4'b0110;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1000;
  localparam logic [3:0] ALUC_MUL = 4'b1001;
  localparam logic [3:0] ALUC_SLT = 4'b1010;

  typedef enum logic {
    IDLE,
    MUL_BUSY
  } alu_state_t;

  function automatic logic alu_is_illegal(input logic [3:0] op);
    return op > ALUC_SLT;
  endfunction

endpackage

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - single-cycle ALU evaluation for every opcode except MUL
module alu_comb
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SH_W       = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [3:0]            opcode,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  overflow,
  output logic                  err
);

  localparam int MSB  = DATA_WIDTH - 1;
  localparam int HALF = DATA_WIDTH / 2;

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] diff;
  logic [SH_W-1:0]     sh;

  assign sh   = a[SH_W-1:0];
  assign sum  = {1'b0, a} + {1'b0, b};
  // Subtract as a + ~b + 1 so the carry out means "no borrow".
  assign diff = {1'b0, a} + {1'b0, ~b} + (DATA_WIDTH+1)'(1);

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    err      = alu_is_illegal(opcode);
    case (opcode)
      ALUC_ADD: begin
        {carry, result} = sum;
        overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      ALUC_SUB: begin
        {carry, result} = diff;
        overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      ALUC_AND: result = a & b;
      ALUC_OR:  result = a | b;
      ALUC_XOR: result = a ^ b;
      ALUC_LUI: result = {b[HALF-1:0], {HALF{1'b0}}};
      ALUC_SLL: result = b << sh;
      ALUC_SRL: result = b >> sh;
      ALUC_SRA: result = $unsigned($signed(b) >>> sh);
      ALUC_SLT: result = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      default:  ;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with valid/ready handshakes and iterative shift-add multiply
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SH_W       = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic [DATA_WIDTH-1:0] dinb,
  input  logic [3:0]            opcode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] doutr,
  output logic                  doutz,
  output logic                  doutn,
  output logic                  flag_c,
  output logic                  flag_of,
  output logic                  err
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  alu_state_t            state;
  alu_state_t            next_state;
  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [DATA_WIDTH-1:0] acc;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] comb_r;
  logic                  comb_c;
  logic                  comb_of;
  logic                  comb_err;
  logic                  accept;
  logic                  is_mul;
  logic                  mul_done;

  alu_comb #(
    .DATA_WIDTH(DATA_WIDTH),
    .SH_W      (SH_W)
  ) u_comb (
    .a       (dina),
    .b       (dinb),
    .opcode  (opcode),
    .result  (comb_r),
    .carry   (comb_c),
    .overflow(comb_of),
    .err     (comb_err)
  );

  assign is_mul   = (opcode == ALUC_MUL);
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign mul_done = (state == MUL_BUSY) && (cnt == CNT_W'(DATA_WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (accept && is_mul) next_state = MUL_BUSY;
      MUL_BUSY: if (mul_done) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Shift-add multiplier: one multiplicand bit per cycle, product kept modulo 2^DATA_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept && is_mul) begin
      mcand  <= dina;
      mplier <= dinb;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == MUL_BUSY && !mul_done) begin
      if (mcand[0]) acc <= acc + mplier;
      mplier <= mplier << 1;
      mcand  <= mcand >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Output register: a load wins over a drain so back-to-back results keep out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      doutr     <= '0;
      doutz     <= 1'b0;
      doutn     <= 1'b0;
      flag_c    <= 1'b0;
      flag_of   <= 1'b0;
      err       <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid <= 1'b1;
      doutr     <= comb_r;
      doutz     <= (comb_r == '0);
      doutn     <= comb_r[DATA_WIDTH-1];
      flag_c    <= comb_c;
      flag_of   <= comb_of;
      err       <= comb_err;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      doutr     <= acc;
      doutz     <= (acc == '0);
      doutn     <= acc[DATA_WIDTH-1];
      flag_c    <= 1'b0;
      flag_of   <= 1'b0;
      err       <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized and directed self-checking bench for alu_pipe
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int DW = 8;
  localparam int SW = $clog2(DW);

  typedef struct packed {
    logic [DW-1:0] r;
    logic          c;
    logic          of;
    logic          z;
    logic          n;
    logic          err;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dina = '0;
  logic [DW-1:0] dinb = '0;
  logic [3:0]    opcode = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] doutr;
  logic          doutz, doutn, flag_c, flag_of, err;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   delivered = 0;
  logic last_acc = 1'b0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  alu_pipe #(.DATA_WIDTH(DW), .SH_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dina(dina), .dinb(dinb), .opcode(opcode), .out_valid(out_valid),
    .out_ready(out_ready), .doutr(doutr), .doutz(doutz), .doutn(doutn),
    .flag_c(flag_c), .flag_of(flag_of), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode definitions.
  function automatic res_t model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] op);
    int ia, ib, sa, sb, sh, s, mask, lim;
    res_t e;
    mask = (1 << DW) - 1;
    lim  = 1 << (DW - 1);
    ia = int'(a);
    ib = int'(b);
    sa = (ia >= lim) ? ia - (1 << DW) : ia;
    sb = (ib >= lim) ? ib - (1 << DW) : ib;
    sh = ia % (1 << SW);
    e = '0;
    s = 0;
    case (op)
      ALUC_ADD: begin s = ia + ib; e.c = (s > mask); e.of = (sa + sb >= lim) || (sa + sb < -lim); end
      ALUC_SUB: begin s = ia + (mask - ib) + 1; e.c = (s > mask); e.of = (sa - sb >= lim) || (sa - sb < -lim); end
      ALUC_AND: s = ia & ib;
      ALUC_OR:  s = ia | ib;
      ALUC_XOR: s = ia ^ ib;
      ALUC_LUI: s = (ib % (1 << (DW / 2))) * (1 << (DW / 2));
      ALUC_SLL: s = ib * (1 << sh);
      ALUC_SRL: s = ib / (1 << sh);
      ALUC_SRA: s = sb >>> sh;
      ALUC_MUL: s = ia * ib;
      ALUC_SLT: s = (sa < sb) ? 1 : 0;
      default:  e.err = 1'b1;
    endcase
    e.r = DW'(s & mask);
    e.z = (e.r == '0);
    e.n = e.r[DW-1];
    return e;
  endfunction

  function automatic res_t dut_res();
    return {doutr, flag_c, flag_of, doutz, doutn, err};
  endfunction

  task automatic chk_res(input string tag, input res_t e);
    chk({tag, "_r"},   doutr,   e.r);
    chk({tag, "_c"},   flag_c,  e.c);
    chk({tag, "_of"},  flag_of, e.of);
    chk({tag, "_z"},   doutz,   e.z);
    chk({tag, "_n"},   doutn,   e.n);
    chk({tag, "_err"}, err,     e.err);
  endtask

  // One cycle of the scoreboarded handshake engine; called at a negedge with inputs already driven.
  task automatic tick();
    res_t held;
    logic hold_v;
    #1;
    last_acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      chk("q_has_entry", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        chk_res("sb", exp_q.pop_front());
        delivered++;
      end
    end
    if (last_acc) exp_q.push_back(model(dina, dinb, opcode));
    hold_v = out_valid && !out_ready;
    held   = dut_res();
    @(negedge clk);
    if (hold_v) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", dut_res(), held);
    end
  endtask

  task automatic run_op(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [3:0] op, input logic [DW-1:0] exp_r);
    int   lat;
    logic busy_rdy;
    res_t e;
    e = model(a, b, op);
    @(negedge clk);
    dina = a; dinb = b; opcode = op; in_valid = 1'b1; out_ready = 1'b0;
    #1 chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    busy_rdy = 1'b0;
    while (!out_valid && lat < 40) begin
      busy_rdy |= in_ready;
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, "_lat"}, lat, (op == ALUC_MUL) ? DW + 1 : 0);
    chk({tag, "_plan"}, doutr, exp_r);
    chk_res(tag, e);
    if (op == ALUC_MUL) chk({tag, "_busy_in_ready"}, busy_rdy, 0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_drained"}, out_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] bp_a [3];
    logic [DW-1:0] bp_b [3];
    int   k;
    logic spur;
    bp_a = '{8'h10, 8'hF0, 8'h7F};
    bp_b = '{8'h20, 8'h20, 8'h7F};

    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_doutr", doutr, 0);
    chk("reset_flags", {doutz, doutn, flag_c, flag_of, err}, 0);
    chk("reset_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("add_ovf",  8'h7F, 8'h01, ALUC_ADD, 8'h80);
    run_op("sub_zero", 8'h05, 8'h05, ALUC_SUB, 8'h00);
    run_op("sub_ovf",  8'h80, 8'h01, ALUC_SUB, 8'h7F);
    run_op("mul_13_11", 8'd13, 8'd11, ALUC_MUL, 8'h8F);
    run_op("mul_ff",   8'hFF, 8'hFF, ALUC_MUL, 8'h01);
    run_op("sra",      8'h0B, 8'h90, ALUC_SRA, 8'hF2);
    run_op("lui",      8'h00, 8'h0A, ALUC_LUI, 8'hA0);
    run_op("slt",      8'hFF, 8'h01, ALUC_SLT, 8'h01);
    run_op("illegal",  8'h12, 8'h34, 4'hC,     8'h00);

    // Backpressure: three ADDs offered while the result register is stalled.
    @(negedge clk);
    exp_q.delete();
    delivered = 0;
    k = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; opcode = ALUC_ADD; dina = bp_a[0]; dinb = bp_b[0];
    for (int cy = 0; cy < 6; cy++) begin
      tick();
      if (last_acc) begin
        k++;
        if (k < 3) begin dina = bp_a[k]; dinb = bp_b[k]; end
        else in_valid = 1'b0;
      end
      #1 chk("bp_in_ready", in_ready, 0);
    end
    chk("bp_accepted", k, 1);
    out_ready = 1'b1;
    for (int cy = 0; cy < 30 && delivered < 3; cy++) begin
      tick();
      if (last_acc) begin
        k++;
        if (k < 3) begin dina = bp_a[k]; dinb = bp_b[k]; end
        else in_valid = 1'b0;
      end
    end
    chk("bp_delivered", delivered, 3);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Random traffic with random backpressure against the scoreboard.
    delivered = 0;
    in_valid = 1'b0;
    last_acc = 1'b0;
    for (int cy = 0; cy < 500; cy++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        dina = DW'($urandom);
        dinb = DW'($urandom);
        opcode = ($urandom_range(0, 4) == 0) ? ALUC_MUL : 4'($urandom_range(0, 15));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int cy = 0; cy < 40 && exp_q.size() > 0; cy++) tick();
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_delivered_some", delivered > 20, 1);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    dina = 8'd13; dinb = 8'd11; opcode = ALUC_MUL; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_doutr", doutr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    spur = 1'b0;
    repeat (14) begin
      @(posedge clk);
      #1 spur |= out_valid;
    end
    chk("rst_no_result", spur, 0);
    run_op("post_rst_add", 8'h21, 8'h12, ALUC_ADD, 8'h33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
